wearout_acq_scheduler: RTL and testbench

// - Parametrised multi-channel acquisition core for on-chip wear-out sensors; sits behind the APB wrapper.
// - Sequences measurements across NUM_CH sensor-wrapper channels: single-shot, masked scan-once or continuous scan.
// - Per-channel req/valid handshake and programmable timeout; results queue in a first-word-fall-through FIFO.
// - Adds timeout, channel tagging, result buffering and overflow status.

---
 rtl/wearout_acq_if.sv | 33 +++
 rtl/wearout_acq_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_wearout_acq_scheduler.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wearout_acq_if.sv
// Bus between the CPU/sensor side and the wear-out acquisition scheduler.
interface wearout_acq_if #(
    parameter int NUM_CH     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int RES_W      = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic                      CmdValid;
    logic [31:0]               CPUCommand;
    logic [NUM_CH-1:0]         ScanMask;
    logic                      STATUS_CLEAR;
    logic [NUM_CH-1:0]         SensorReq;
    logic [NUM_CH-1:0]         SensorValid;
    logic [NUM_CH*RES_W-1:0]   SensorResult;
    logic [NUM_CH*3-1:0]       SensorError;
    logic                      ResultPop;
    logic [31:0]               ResultForCPU;
    logic [LVL_W-1:0]          FifoLevel;
    logic [3:0]                StatusBits;

    modport master (
        output CmdValid, CPUCommand, ScanMask, STATUS_CLEAR,
        output SensorValid, SensorResult, SensorError, ResultPop,
        input  SensorReq, ResultForCPU, FifoLevel, StatusBits
    );

    modport slave (
        input  CmdValid, CPUCommand, ScanMask, STATUS_CLEAR,
        input  SensorValid, SensorResult, SensorError, ResultPop,
        output SensorReq, ResultForCPU, FifoLevel, StatusBits
    );
endinterface

// File: rtl/wearout_acq_scheduler.sv
// Multi-channel wear-out sensor acquisition scheduler with a first-word-fall-through result FIFO.
// Define ACQ_STALL_ON_FULL_EN to hold the measurement on a full FIFO instead of dropping the result.
module wearout_acq_scheduler #(
    parameter int NUM_CH     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int RES_W      = 16
) (
    input logic          Clk,
    input logic          Rst,
    wearout_acq_if.slave bus
);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = RES_W + 9;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_ADV = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [1:0]         mode_q;
    logic [5:0]         ch_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [11:0]        thr_q, cnt_q;
    logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [LVL_W-1:0]   level_q;
    logic               done_q, err_q, ovf_q;

    logic [1:0]         cmd_mode_s;
    logic [5:0]         cmd_ch_s, adv_ch_s;
    logic [11:0]        cmd_thr_s;
    logic               stop_s, start_s, start_ok_s, more_s;
    logic [6:0]         first_s, next_s, wrap_s;
    logic               cur_valid_s, timeout_s, evt_s, req_evt_s, fire_s, stall_s;
    logic [RES_W-1:0]   cur_res_s;
    logic [2:0]         cur_err_s;
    logic [ENT_W-1:0]   live_ent_s, ent_s, head_s;
    logic               full_s, empty_s, pop_s, push_s, drop_s;
    logic               done_set_s, err_set_s, busy_s, unused_s;
    logic [NUM_CH-1:0]  req_s;
    logic [15:0]        val_s;

    // Returns {found, index} of the lowest set bit of m at or above start.
    function automatic logic [6:0] find_from(input logic [NUM_CH-1:0] m, input int start);
        logic [6:0] r;
        r = 7'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            r = (i >= start && m[i]) ? {1'b1, 6'(i)} : r;
        end
        return r;
    endfunction

    assign cmd_mode_s = bus.CPUCommand[31:30];
    assign cmd_ch_s   = bus.CPUCommand[29:24];
    assign cmd_thr_s  = bus.CPUCommand[23:12];
    assign unused_s   = ^bus.CPUCommand[11:0];
    assign stop_s     = bus.CmdValid && (cmd_mode_s == 2'b00);
    assign start_s    = bus.CmdValid && (cmd_mode_s != 2'b00) && (state_q == S_IDLE);
    assign first_s    = (cmd_mode_s == 2'b01) ? {(int'(cmd_ch_s) < NUM_CH), cmd_ch_s}
                                              : find_from(bus.ScanMask, 0);
    assign start_ok_s = first_s[6];
    assign next_s     = find_from(mask_q, int'(ch_q) + 1);
    assign wrap_s     = find_from(mask_q, 0);

    // Channel to visit after the inter-request gap
    always_comb begin
        more_s   = 1'b0;
        adv_ch_s = ch_q;
        if (mode_q == 2'b01) begin
            more_s = 1'b0;
        end else if (next_s[6]) begin
            more_s   = 1'b1;
            adv_ch_s = next_s[5:0];
        end else if (mode_q == 2'b11) begin
            more_s   = wrap_s[6];
            adv_ch_s = wrap_s[5:0];
        end else begin
            more_s = 1'b0;
        end
    end

    // Select the handshake of the channel being measured
    always_comb begin
        cur_valid_s = 1'b0;
        cur_res_s   = '0;
        cur_err_s   = 3'b000;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_valid_s = (ch_q == 6'(i)) ? bus.SensorValid[i] : cur_valid_s;
            cur_res_s   = (ch_q == 6'(i)) ? bus.SensorResult[i*RES_W +: RES_W] : cur_res_s;
            cur_err_s   = (ch_q == 6'(i)) ? bus.SensorError[i*3 +: 3] : cur_err_s;
        end
    end

    assign timeout_s  = (thr_q != 12'd0) && (cnt_q == thr_q - 12'd1);
    assign live_ent_s = cur_valid_s ? {cur_res_s, cur_err_s, ch_q} : {{RES_W{1'b0}}, 3'b111, ch_q};
    assign full_s     = (level_q == LVL_W'(FIFO_DEPTH));
    assign empty_s    = (level_q == LVL_W'(0));
    assign pop_s      = bus.ResultPop && !empty_s;

`ifdef ACQ_STALL_ON_FULL_EN
    logic             pend_q;
    logic [ENT_W-1:0] pend_ent_q;

    assign evt_s   = pend_q || cur_valid_s || timeout_s;
    assign ent_s   = pend_q ? pend_ent_q : live_ent_s;
    assign stall_s = req_evt_s && full_s && !pop_s;

    // Result captured while the FIFO is full, released on the first push opportunity
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend_q     <= 1'b0;
            pend_ent_q <= '0;
        end else if (stall_s) begin
            pend_q     <= 1'b1;
            pend_ent_q <= ent_s;
        end else if (fire_s || stop_s) begin
            pend_q     <= 1'b0;
        end
    end
`else
    assign evt_s   = cur_valid_s || timeout_s;
    assign ent_s   = live_ent_s;
    assign stall_s = 1'b0;
`endif

    // A stop in the same cycle as a result discards the result
    assign req_evt_s = (state_q == S_REQ) && evt_s && !stop_s;
    assign fire_s    = req_evt_s && !stall_s;
    assign push_s    = fire_s && (!full_s || pop_s);
    assign drop_s    = fire_s && full_s && !pop_s;

    assign done_set_s = ((state_q == S_ADV) && !stop_s && !more_s) ||
                        (start_s && (cmd_mode_s != 2'b01) && !start_ok_s);
    assign err_set_s  = fire_s && (ent_s[8:6] != 3'b001);

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = (start_s && start_ok_s) ? S_REQ : S_IDLE;
            S_REQ: begin
                if (stop_s)      state_d = S_IDLE;
                else if (fire_s) state_d = S_ADV;
                else             state_d = S_REQ;
            end
            S_ADV: begin
                if (stop_s)      state_d = S_IDLE;
                else if (more_s) state_d = S_REQ;
                else             state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: one-hot request and busy flag
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            req_s[i] = (state_q == S_REQ) && (ch_q == 6'(i));
        end
        busy_s = (state_q != S_IDLE);
    end

    // Command latch, channel sequencing and timeout counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mode_q <= 2'b00;
            ch_q   <= 6'd0;
            mask_q <= '0;
            thr_q  <= 12'd0;
            cnt_q  <= 12'd0;
        end else if (start_s && start_ok_s) begin
            mode_q <= cmd_mode_s;
            ch_q   <= first_s[5:0];
            mask_q <= bus.ScanMask;
            thr_q  <= cmd_thr_s;
            cnt_q  <= 12'd0;
        end else if ((state_q == S_REQ) && !evt_s) begin
            cnt_q  <= cnt_q + 12'd1;
        end else if ((state_q == S_ADV) && more_s) begin
            ch_q   <= adv_ch_s;
            cnt_q  <= 12'd0;
        end
    end

    // Sticky status; a set in the same cycle as STATUS_CLEAR wins
    always_ff @(posedge Clk) begin
        if (Rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= done_set_s || (done_q && !bus.STATUS_CLEAR);
            err_q  <= err_set_s  || (err_q  && !bus.STATUS_CLEAR);
            ovf_q  <= drop_s     || (ovf_q  && !bus.STATUS_CLEAR);
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_s) wr_q <= wr_q + AW'(1);
            if (pop_s)  rd_q <= rd_q + AW'(1);
            level_q <= level_q + LVL_W'(push_s) - LVL_W'(pop_s);
        end
    end

    // FIFO storage
    always_ff @(posedge Clk) begin
        if (push_s) mem_q[wr_q] <= ent_s;
    end

    // Head-of-FIFO formatting for the CPU
    always_comb begin
        head_s = mem_q[rd_q];
        val_s  = 16'd0;
        val_s[RES_W-1:0] = head_s[ENT_W-1:9];
        if (empty_s) bus.ResultForCPU = 32'd0;
        else         bus.ResultForCPU = {val_s, head_s[8:6], head_s[5:0], 6'd0, 1'b1};
    end

    assign bus.SensorReq  = req_s;
    assign bus.FifoLevel  = level_q;
    assign bus.StatusBits = {ovf_q, busy_s, err_q, done_q};
endmodule

// File: tb/tb_wearout_acq_scheduler.sv
// Randomised bench for wearout_acq_scheduler against a transaction-level model with a queue-based FIFO.
module tb_wearout_acq_scheduler;
    localparam int NUM_CH = 8, FIFO_DEPTH = 8, RES_W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wearout_acq_if #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .RES_W(RES_W)) bus_if ();
    wearout_acq_scheduler #(.NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .RES_W(RES_W)) dut (
        .Clk(clk), .Rst(rst), .bus(bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: measuring/gap phases, queue of formatted CPU words, sticky bits
    bit          m_meas = 0, m_gap = 0, m_done = 0, m_err = 0, m_ovf = 0, m_pend = 0;
    int          m_mode = 0, m_ch = 0, m_thr = 0, m_waited = 0;
    logic [NUM_CH-1:0] m_mask = '0;
    logic [31:0] m_pend_w = 32'd0;
    logic [31:0] m_fifo[$];

    int          resp_mode = 0, resp_delay = 0;
    logic [15:0] resp_val = 16'h0000;
    int          exp_ch[4] = '{0, 2, 5, 7};

    function automatic logic [31:0] mk(input logic [15:0] val, input logic [2:0] err, input int ch);
        return (32'(val) << 16) | (32'(err) << 13) | (32'(ch) << 7) | 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit pop, push, stop, set_done, set_err, set_ovf;
        int sz, mode;
        logic [31:0] cmd, w;
        push = 0; set_done = 0; set_err = 0; set_ovf = 0; w = 32'd0;
        if (rst) begin
            m_meas = 0; m_gap = 0; m_done = 0; m_err = 0; m_ovf = 0; m_pend = 0;
            m_fifo.delete();
        end else begin
            cmd  = bus_if.CPUCommand;
            mode = int'(cmd[31:30]);
            stop = bus_if.CmdValid && (mode == 0);
            sz   = m_fifo.size();
            pop  = bus_if.ResultPop && (sz > 0);
            if (m_meas) begin
                if (stop) begin
                    m_meas = 0; m_pend = 0;
                end else begin
                    bit v, to;
                    v  = bus_if.SensorValid[m_ch];
                    to = (m_thr != 0) && (m_waited + 1 == m_thr);
                    if (m_pend || v || to) begin
                        if (m_pend) w = m_pend_w;
                        else if (v) w = mk(bus_if.SensorResult[m_ch*RES_W +: RES_W], bus_if.SensorError[m_ch*3 +: 3], m_ch);
                        else        w = mk(16'd0, 3'b111, m_ch);
                        if (sz < FIFO_DEPTH || pop) push = 1;
`ifdef ACQ_STALL_ON_FULL_EN
                        else begin m_pend = 1; m_pend_w = w; end
`else
                        else set_ovf = 1;
`endif
                        if (push || set_ovf) begin
                            m_meas = 0; m_gap = 1; m_pend = 0;
                            if (w[15:13] != 3'b001) set_err = 1;
                        end
                    end else begin
                        m_waited++;
                    end
                end
            end else if (m_gap) begin
                m_gap = 0;
                if (!stop) begin
                    int nxt = -1;
                    if (m_mode != 1)
                        for (int c = m_ch + 1; c < NUM_CH; c++) if (m_mask[c] && nxt < 0) nxt = c;
                    if (nxt < 0 && m_mode == 3)
                        for (int c = 0; c < NUM_CH; c++) if (m_mask[c] && nxt < 0) nxt = c;
                    if (nxt >= 0) begin m_meas = 1; m_ch = nxt; m_waited = 0; end
                    else set_done = 1;
                end
            end else if (bus_if.CmdValid && mode != 0) begin
                int first = -1;
                if (mode == 1) begin
                    if (int'(cmd[29:24]) < NUM_CH) first = int'(cmd[29:24]);
                end else begin
                    for (int c = 0; c < NUM_CH; c++) if (bus_if.ScanMask[c] && first < 0) first = c;
                    if (first < 0) set_done = 1;
                end
                if (first >= 0) begin
                    m_meas = 1; m_ch = first; m_waited = 0; m_mode = mode;
                    m_mask = bus_if.ScanMask; m_thr = int'(cmd[23:12]);
                end
            end
            if (pop)  void'(m_fifo.pop_front());
            if (push) m_fifo.push_back(w);
            m_done = set_done || (m_done && !bus_if.STATUS_CLEAR);
            m_err  = set_err  || (m_err  && !bus_if.STATUS_CLEAR);
            m_ovf  = set_ovf  || (m_ovf  && !bus_if.STATUS_CLEAR);
        end
    endtask

    task automatic compare_all();
        logic [31:0] exp_req, exp_head;
        exp_req  = m_meas ? (32'd1 << m_ch) : 32'd0;
        exp_head = (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
        check("SensorReq", 32'(bus_if.SensorReq), exp_req);
        check("ResultForCPU", bus_if.ResultForCPU, exp_head);
        check("FifoLevel", 32'(bus_if.FifoLevel), 32'(m_fifo.size()));
        check("StatusBits", 32'(bus_if.StatusBits), {28'd0, m_ovf, (m_meas || m_gap), m_err, m_done});
        check("req_onehot", 32'($countones(bus_if.SensorReq) <= 1), 32'd1);
    endtask

    task automatic drive_sensors();
        for (int i = 0; i < NUM_CH; i++) begin
            case (resp_mode)
                1: begin
                    bus_if.SensorValid[i] = m_meas && (m_ch == i) && (m_waited == resp_delay);
                    bus_if.SensorResult[i*RES_W +: RES_W] = resp_val;
                    bus_if.SensorError[i*3 +: 3] = 3'b001;
                end
                2: begin
                    bus_if.SensorValid[i] = ($urandom_range(0, 3) == 0);
                    bus_if.SensorResult[i*RES_W +: RES_W] = 16'($urandom);
                    bus_if.SensorError[i*3 +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
                end
                default: begin
                    bus_if.SensorValid[i] = 1'b0;
                    bus_if.SensorResult[i*RES_W +: RES_W] = 16'd0;
                    bus_if.SensorError[i*3 +: 3] = 3'b001;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        drive_sensors();
    endtask

    task automatic send_cmd(input logic [31:0] cmd, input logic [NUM_CH-1:0] mask);
        bus_if.CPUCommand = cmd;
        bus_if.ScanMask   = mask;
        bus_if.CmdValid   = 1'b1;
        tick();
        bus_if.CmdValid   = 1'b0;
    endtask

    task automatic run_idle(input int bound);
        int k = 0;
        while ((m_meas || m_gap) && k < bound) begin tick(); k++; end
        check("idle_bound", 32'(k < bound), 32'd1);
    endtask

    task automatic pulse(input int which);
        if (which == 0) bus_if.ResultPop = 1'b1; else bus_if.STATUS_CLEAR = 1'b1;
        tick();
        bus_if.ResultPop = 1'b0;
        bus_if.STATUS_CLEAR = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus_if.CmdValid = 1'b0; bus_if.CPUCommand = 32'd0; bus_if.ScanMask = '0;
        bus_if.STATUS_CLEAR = 1'b0; bus_if.ResultPop = 1'b0;
        bus_if.SensorValid = '0; bus_if.SensorResult = '0; bus_if.SensorError = '0;
        tick(); tick();
        check("reset_req", 32'(bus_if.SensorReq), 32'd0);
        check("reset_head", bus_if.ResultForCPU, 32'd0);
        check("reset_level", 32'(bus_if.FifoLevel), 32'd0);
        check("reset_status", 32'(bus_if.StatusBits), 32'd0);
        rst = 1'b0;

        // Single shot on channel 3, result after 5 cycles
        resp_mode = 1; resp_delay = 5; resp_val = 16'h1234;
        send_cmd({2'b01, 6'd3, 12'd0, 12'd0}, 8'h00);
        run_idle(30);
        check("single_head", bus_if.ResultForCPU, 32'h1234_2181);
        check("single_status", 32'(bus_if.StatusBits), 32'h1);
        check("single_level", 32'(bus_if.FifoLevel), 32'd1);
        pulse(0);

        // Scan-once over channels 0,2,5,7
        pulse(1);
        resp_delay = 2; resp_val = 16'hBEEF;
        send_cmd({2'b10, 6'd0, 12'd0, 12'd0}, 8'hA5);
        run_idle(80);
        check("scan_level", 32'(bus_if.FifoLevel), 32'd4);
        check("scan_status", 32'(bus_if.StatusBits), 32'h1);
        for (int k = 0; k < 4; k++) begin
            check("scan_order", 32'(bus_if.ResultForCPU[12:7]), 32'(exp_ch[k]));
            pulse(0);
        end

        // Timeout of 10 cycles on channel 1
        pulse(1);
        resp_mode = 0;
        send_cmd({2'b01, 6'd1, 12'd10, 12'd0}, 8'h00);
        repeat (9) tick();
        check("to_early", 32'(bus_if.FifoLevel), 32'd0);
        tick();
        check("to_level", 32'(bus_if.FifoLevel), 32'd1);
        check("to_head", bus_if.ResultForCPU, 32'h0000_E081);
        check("to_status_adv", 32'(bus_if.StatusBits), 32'h6);
        tick();
        check("to_status_done", 32'(bus_if.StatusBits), 32'h3);
        pulse(1);
        check("to_cleared", 32'(bus_if.StatusBits), 32'h0);
        pulse(0);

        // Continuous scan into a full FIFO
        resp_mode = 1; resp_delay = 0; resp_val = 16'h0042;
        send_cmd({2'b11, 6'd0, 12'd0, 12'd0}, 8'h03);
        repeat (24) tick();
        check("cont_level", 32'(bus_if.FifoLevel), 32'd8);
`ifdef ACQ_STALL_ON_FULL_EN
        check("stall_no_ovf", 32'(bus_if.StatusBits[3]), 32'd0);
        check("stall_req_held", 32'(bus_if.SensorReq != 0), 32'd1);
        pulse(0);
        check("stall_release_level", 32'(bus_if.FifoLevel), 32'd8);
        check("stall_release_req", 32'(bus_if.SensorReq), 32'd0);
`else
        check("cont_ovf", 32'(bus_if.StatusBits[3]), 32'd1);
`endif
        send_cmd(32'd0, 8'h00);
        check("cont_stop_req", 32'(bus_if.SensorReq), 32'd0);
        check("cont_stop_busy", 32'(bus_if.StatusBits[2]), 32'd0);

        // Push and pop together on a full FIFO
        pulse(1);
        resp_val = 16'h0777;
        send_cmd({2'b11, 6'd0, 12'd0, 12'd0}, 8'h01);
        for (int k = 0; k < 6; k++) begin
            bus_if.ResultPop = m_meas;
            tick();
        end
        bus_if.ResultPop = 1'b0;
        check("pp_level", 32'(bus_if.FifoLevel), 32'd8);
        check("pp_ovf", 32'(bus_if.StatusBits[3]), 32'd0);
        send_cmd(32'd0, 8'h00);

        // Stop and reset in the middle of a request
        resp_mode = 0;
        send_cmd({2'b01, 6'd2, 12'd0, 12'd0}, 8'h00);
        repeat (3) tick();
        send_cmd(32'd0, 8'h00);
        check("stop_req", 32'(bus_if.SensorReq), 32'd0);
        check("stop_level", 32'(bus_if.FifoLevel), 32'd8);
        send_cmd({2'b01, 6'd4, 12'd0, 12'd0}, 8'h00);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_req", 32'(bus_if.SensorReq), 32'd0);
        check("rst_level", 32'(bus_if.FifoLevel), 32'd0);
        check("rst_status", 32'(bus_if.StatusBits), 32'd0);

        // Randomised traffic
        resp_mode = 2;
        for (int n = 0; n < 4000; n++) begin
            bus_if.CmdValid     = ($urandom_range(0, 24) == 0);
            bus_if.CPUCommand   = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 9)),
                                   ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom_range(1, 20)), 12'd0};
            bus_if.ScanMask     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus_if.ResultPop    = ($urandom_range(0, 2) == 0);
            bus_if.STATUS_CLEAR = ($urandom_range(0, 15) == 0);
            rst                 = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
